// File: rtl/stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1_4
// Purpose  : 1-to-4 stream demultiplexer with a one-word register buffer per
//            lane. Optional macro DEMUX_RR_EN selects lanes round-robin
//            instead of from in_sel.
// Revision : 1.0  initial release
// ============================================================================
module stream_demux_1_4 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data_0,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    output logic [DATA_W-1:0] out_data_3,
    output logic              out_valid_0,
    output logic              out_valid_1,
    output logic              out_valid_2,
    output logic              out_valid_3,
    input  logic              out_ready_0,
    input  logic              out_ready_1,
    input  logic              out_ready_2,
    input  logic              out_ready_3,
    output logic [15:0]       accept_cnt,
    output logic              busy
);

    logic [3:0]        out_ready_w;
    logic [3:0]        lane_valid_w;
    logic [DATA_W-1:0] lane_data_w [4];
    logic [1:0]        tgt_w;
    logic              accept_w;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;

    assign out_ready_w = {out_ready_3, out_ready_2, out_ready_1, out_ready_0};

`ifdef DEMUX_RR_EN
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic       unused_sel_w;

    assign unused_sel_w = ^in_sel;
    assign ptr_d        = accept_w ? ptr_q + 2'd1 : ptr_q;
    assign tgt_w        = ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign tgt_w = in_sel;
`endif

    // A full target lane can still accept when it drains in the same cycle.
    assign in_ready = !rst && (!lane_valid_w[tgt_w] || out_ready_w[tgt_w]);
    assign accept_w = in_valid && in_ready;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            logic              valid_q;
            logic              valid_d;
            logic [DATA_W-1:0] data_q;
            logic [DATA_W-1:0] data_d;
            logic              fill_w;
            logic              drain_w;

            assign fill_w  = accept_w && (tgt_w == 2'(k));
            assign drain_w = valid_q && out_ready_w[k];

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (fill_w) begin
                    valid_d = 1'b1;
                    data_d  = in_data;
                end else if (drain_w) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign lane_valid_w[k] = valid_q;
            assign lane_data_w[k]  = data_q;
        end
    endgenerate

    assign cnt_d = accept_w ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_data_0  = lane_data_w[0];
    assign out_data_1  = lane_data_w[1];
    assign out_data_2  = lane_data_w[2];
    assign out_data_3  = lane_data_w[3];
    assign out_valid_0 = lane_valid_w[0];
    assign out_valid_1 = lane_valid_w[1];
    assign out_valid_2 = lane_valid_w[2];
    assign out_valid_3 = lane_valid_w[3];
    assign accept_cnt  = cnt_q;
    assign busy        = |lane_valid_w;

endmodule
`default_nettype wire
